// File: rtl/cache_flush_seq_pkg.sv
// Shared types and constants for the cache flush sequencer.
package cache_flush_seq_pkg;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_WAIT_L1,
    FS_L2_START,
    FS_WAIT_L2
  } flush_state_t;

  localparam int MAX_NUM_L1 = 8;
  localparam int L1D_CH     = 0;
  localparam int L1I_CH     = 1;

endpackage

// File: rtl/flush_watchdog.sv
// Saturating wait-state watchdog: synchronous clear, count enable, expiry flag.
module flush_watchdog #(
  parameter int LG_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [LG_TIMEOUT-1:0] COUNT_MAX = '1;

  logic [LG_TIMEOUT-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != COUNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flags the cycle whose increment reaches all-ones, so a wait state lasts
  // exactly 2**LG_TIMEOUT-1 cycles before the sequencer abandons it.
  assign expired = enable && !clear && (count_d == COUNT_MAX);

endmodule

// File: rtl/cache_flush_seq.sv
// Flush sequencer: gathers L1 flush requests, waits for all L1 completions, then flushes L2.
module cache_flush_seq
  import cache_flush_seq_pkg::*;
#(
  parameter int NUM_L1     = 2,
  parameter int LG_TIMEOUT = 16,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_L1-1:0] flush_req,
  input  logic [NUM_L1-1:0] l1_flush_complete,
  input  logic              l2_bypass,
  input  logic              l2_flush_complete,
  output logic              flush_l2,
  output logic              in_flush_mode,
  output logic              flush_done,
  output logic [NUM_L1-1:0] pending_mask,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  flush_count
);

  flush_state_t      state_q, state_d;
  logic [NUM_L1-1:0] pending_q, pending_d;
  logic [NUM_L1-1:0] queued_q, queued_d;
  logic [NUM_L1-1:0] req_all;
  logic              bypass_q, bypass_d;
  logic              in_flush_q, in_flush_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wd_clear, wd_enable, wd_expired;

  flush_watchdog #(
    .LG_TIMEOUT(LG_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  assign req_all = flush_req | queued_q;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    queued_d   = queued_q;
    bypass_d   = bypass_q;
    in_flush_d = in_flush_q;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    count_d    = count_q;
    wd_clear   = 1'b1;
    wd_enable  = 1'b0;

    unique case (state_q)
      FS_IDLE: begin
        if (req_all != '0) begin
          pending_d  = req_all & ~l1_flush_complete;
          bypass_d   = l2_bypass;
          queued_d   = '0;
          in_flush_d = 1'b1;
          state_d    = FS_WAIT_L1;
        end
      end

      FS_WAIT_L1: begin
        queued_d  = queued_q | flush_req;
        wd_clear  = 1'b0;
        wd_enable = 1'b1;
        pending_d = pending_q & ~l1_flush_complete;
        // A completing L1 takes priority over a watchdog expiry in the same cycle.
        if (pending_d == '0) begin
          if (bypass_q) begin
            state_d    = FS_IDLE;
            done_d     = 1'b1;
            in_flush_d = 1'b0;
            count_d    = count_q + 1'b1;
          end else begin
            state_d = FS_L2_START;
          end
        end else if (wd_expired) begin
          state_d    = FS_IDLE;
          pending_d  = '0;
          done_d     = 1'b1;
          in_flush_d = 1'b0;
          timeout_d  = 1'b1;
        end
      end

      FS_L2_START: begin
        queued_d = queued_q | flush_req;
        state_d  = FS_WAIT_L2;
      end

      FS_WAIT_L2: begin
        queued_d  = queued_q | flush_req;
        wd_clear  = 1'b0;
        wd_enable = 1'b1;
        if (l2_flush_complete) begin
          state_d    = FS_IDLE;
          done_d     = 1'b1;
          in_flush_d = 1'b0;
          count_d    = count_q + 1'b1;
        end else if (wd_expired) begin
          state_d    = FS_IDLE;
          done_d     = 1'b1;
          in_flush_d = 1'b0;
          timeout_d  = 1'b1;
        end
      end

      default: begin
        state_d = FS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FS_IDLE;
      pending_q  <= '0;
      queued_q   <= '0;
      bypass_q   <= 1'b0;
      in_flush_q <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      queued_q   <= queued_d;
      bypass_q   <= bypass_d;
      in_flush_q <= in_flush_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      count_q    <= count_d;
    end
  end

  assign flush_l2      = (state_q == FS_L2_START);
  assign in_flush_mode = in_flush_q;
  assign flush_done    = done_q;
  assign pending_mask  = pending_q;
  assign timeout_err   = timeout_q;
  assign flush_count   = count_q;

endmodule

// File: tb/tb_cache_flush_seq.sv
// Randomised self-checking bench for cache_flush_seq against an event-time reference model.
module tb_cache_flush_seq;
  import cache_flush_seq_pkg::*;

  localparam int NL1 = 2;
  localparam int LGT = 4;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [NL1-1:0] flush_req = '0;
  logic [NL1-1:0] l1_flush_complete = '0;
  logic           l2_bypass = 1'b0;
  logic           l2_flush_complete = 1'b0;
  logic           flush_l2;
  logic           in_flush_mode;
  logic           flush_done;
  logic [NL1-1:0] pending_mask;
  logic           timeout_err;
  logic [CW-1:0]  flush_count;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ref_count = 0;
  logic ref_terr = 1'b0;

  cache_flush_seq #(
    .NUM_L1    (NL1),
    .LG_TIMEOUT(LGT),
    .CNT_W     (CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .flush_req        (flush_req),
    .l1_flush_complete(l1_flush_complete),
    .l2_bypass        (l2_bypass),
    .l2_flush_complete(l2_flush_complete),
    .flush_l2         (flush_l2),
    .in_flush_mode    (in_flush_mode),
    .flush_done       (flush_done),
    .pending_mask     (pending_mask),
    .timeout_err      (timeout_err),
    .flush_count      (flush_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    flush_req         = '0;
    l1_flush_complete = '0;
    l2_bypass         = 1'b0;
    l2_flush_complete = 1'b0;
  endtask

  // Cycle 0 is the accept cycle. Channel completions land at cycles d0/d1, the
  // L2 completes l2d cycles after the flush_l2 pulse, an optional extra request
  // arrives at extra_at (mid-sequence) and runs as a bypass sequence afterwards.
  task automatic run_seq(input string name, input logic [1:0] req, input logic byp,
                         input int d0, input int d1, input int l2d,
                         input logic [1:0] extra, input int extra_at, input logic noise);
    int l1_end, l2_at, exp_l2, exp_done, last;
    int got_l2, got_done, n_l2, n_done;
    l1_end = 0;
    if (req[L1D_CH]) l1_end = d0;
    if (req[L1I_CH] && d1 > l1_end) l1_end = d1;
    l2_at    = l1_end + 1 + l2d;
    exp_l2   = byp ? -1 : l1_end + 1;
    exp_done = byp ? l1_end + 1 : l2_at + 1;
    last     = (extra != '0) ? exp_done + 2 : exp_done;
    got_l2 = -1; got_done = -1; n_l2 = 0; n_done = 0;

    flush_req         = req;
    l2_bypass         = byp;
    l1_flush_complete = '0;
    l2_flush_complete = 1'b0;
    for (int c = 1; c <= last; c++) begin
      step();
      if (flush_l2) begin
        n_l2++;
        if (got_l2 < 0) got_l2 = c;
      end
      if (flush_done) begin
        n_done++;
        if (got_done < 0) got_done = c;
      end
      if (c == 1) begin
        check_val({name, ".pending_start"}, 32'(pending_mask), 32'(req));
        check_val({name, ".mode_start"}, 32'(in_flush_mode), 32'd1);
      end
      if (c == exp_done) begin
        ref_count++;
        check_val({name, ".mode_end"}, 32'(in_flush_mode), 32'd0);
        check_val({name, ".count"}, 32'(flush_count), 32'(ref_count));
      end
      if (extra != '0 && c == exp_done + 1) begin
        check_val({name, ".queued_pending"}, 32'(pending_mask), 32'(extra));
        check_val({name, ".queued_mode"}, 32'(in_flush_mode), 32'd1);
      end
      if (extra != '0 && c == exp_done + 2) begin
        ref_count++;
        check_val({name, ".queued_done"}, 32'(flush_done), 32'd1);
        check_val({name, ".queued_count"}, 32'(flush_count), 32'(ref_count));
      end
      // stimulus for cycle c; bypass is driven high after cycle 0 to prove it is latched
      flush_req         = (c == extra_at) ? extra : 2'b00;
      l2_bypass         = 1'b1;
      l1_flush_complete = '0;
      if (req[L1D_CH] && c == d0) l1_flush_complete[L1D_CH] = 1'b1;
      if (req[L1I_CH] && c == d1) l1_flush_complete[L1I_CH] = 1'b1;
      if (extra != '0 && c == exp_done + 1) l1_flush_complete = l1_flush_complete | extra;
      l2_flush_complete = !byp && (c == l2_at);
      if (noise && c < exp_done) begin
        l1_flush_complete = l1_flush_complete | (~req & 2'($urandom));
        if (c <= l1_end) l2_flush_complete = l2_flush_complete | 1'($urandom % 2);
      end
    end
    check_val({name, ".l2_pulses"}, 32'(n_l2), byp ? 32'd0 : 32'd1);
    check_val({name, ".l2_cycle"}, 32'(got_l2), 32'(exp_l2));
    check_val({name, ".done_cycle"}, 32'(got_done), 32'(exp_done));
    check_val({name, ".done_pulses"}, 32'(n_done), (extra != '0) ? 32'd2 : 32'd1);
    check_val({name, ".timeout_err"}, 32'(timeout_err), 32'(ref_terr));
    drive_idle();
    step();
    check_val({name, ".idle_mode"}, 32'(in_flush_mode), 32'd0);
    $display("seq %s req=%b byp=%0d extra=%b l2@%0d done@%0d count=%0d",
             name, req, byp, extra, got_l2, got_done, flush_count);
  endtask

  // No completion ever arrives in the chosen wait state; the watchdog must end it.
  task automatic run_timeout(input string name, input logic in_l2);
    int wait_start, exp_done, got_done;
    wait_start = in_l2 ? 3 : 1;
    exp_done   = wait_start + (1 << LGT) - 1;
    got_done   = -1;
    flush_req  = 2'b01;
    l2_bypass  = 1'b0;
    for (int c = 1; c <= exp_done + 1; c++) begin
      step();
      if (flush_done && got_done < 0) got_done = c;
      if (c == exp_done) begin
        ref_terr = 1'b1;
        check_val({name, ".timeout_err"}, 32'(timeout_err), 32'd1);
        check_val({name, ".count_kept"}, 32'(flush_count), 32'(ref_count));
        check_val({name, ".pending_clr"}, 32'(pending_mask), 32'd0);
        check_val({name, ".mode_end"}, 32'(in_flush_mode), 32'd0);
      end
      flush_req         = '0;
      l1_flush_complete = (in_l2 && c == 1) ? 2'b01 : 2'b00;
    end
    check_val({name, ".done_cycle"}, 32'(got_done), 32'(exp_done));
    drive_idle();
    step();
    $display("seq %s timeout done@%0d count=%0d terr=%0d", name, got_done, flush_count, timeout_err);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [1:0] rq, ex;
    int a, b, l, ea, lim;
    #2;
    check_val("reset.pending", 32'(pending_mask), 32'd0);
    check_val("reset.mode", 32'(in_flush_mode), 32'd0);
    check_val("reset.done", 32'(flush_done), 32'd0);
    check_val("reset.l2", 32'(flush_l2), 32'd0);
    check_val("reset.terr", 32'(timeout_err), 32'd0);
    check_val("reset.count", 32'(flush_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();

    run_seq("t1_both", 2'b11, 1'b0, 3, 5, 3, 2'b00, 0, 1'b0);
    run_seq("t2_bypass", 2'b01, 1'b1, 2, 1, 1, 2'b00, 0, 1'b0);
    run_seq("t3_same_cycle", 2'b11, 1'b0, 4, 4, 2, 2'b00, 0, 1'b0);
    run_seq("t4_queue_in_l2", 2'b01, 1'b0, 1, 1, 5, 2'b10, 4, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rq  = 2'($urandom_range(1, 3));
      a   = $urandom_range(1, 8);
      b   = $urandom_range(1, 8);
      l   = $urandom_range(1, 8);
      ex  = ($urandom % 3 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      lim = 0;
      if (rq[L1D_CH]) lim = a;
      if (rq[L1I_CH] && b > lim) lim = b;
      ea  = $urandom_range(1, lim);
      run_seq($sformatf("rnd%0d", i), rq, 1'($urandom % 2), a, b, l, ex, ea, 1'b1);
    end

    run_timeout("t5_timeout_l1", 1'b0);
    run_seq("t5_after_timeout", 2'b10, 1'b0, 1, 2, 2, 2'b00, 0, 1'b0);
    run_timeout("t5_timeout_l2", 1'b1);

    // reset asserted mid-cycle in WAIT_L1 with a request queued
    flush_req = 2'b11;
    l2_bypass = 1'b0;
    step();
    flush_req = 2'b10;
    step();
    flush_req = 2'b00;
    #3;
    reset = 1'b0;
    #1;
    ref_count = 0;
    ref_terr  = 1'b0;
    check_val("t6.pending", 32'(pending_mask), 32'd0);
    check_val("t6.mode", 32'(in_flush_mode), 32'd0);
    check_val("t6.done", 32'(flush_done), 32'd0);
    check_val("t6.terr", 32'(timeout_err), 32'd0);
    check_val("t6.count", 32'(flush_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check_val("t6.queue_lost_mode", 32'(in_flush_mode), 32'd0);
      check_val("t6.queue_lost_pending", 32'(pending_mask), 32'd0);
    end
    $display("seq t6_reset count=%0d terr=%0d", flush_count, timeout_err);
    run_seq("t6_after_reset", 2'b11, 1'b0, 2, 1, 1, 2'b00, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
